// File: rtl/bck_lp_dtct.sv
// Backward-loop detect stage in front of the loop acceleration table.
// Registers the fetch bundle and flags the oldest confident backward branch.
module bck_lp_dtct #(
  parameter logic [3:0] BR_OPC  = 4'hC,
  parameter int         ENTRIES = 8,
  parameter int         IDX_W   = 3,
  parameter int         THRESH  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] inst_in,
  input  logic [63:0] pc_in,
  input  logic [3:0]  inst_valid_in,
  input  logic        stall_in,
  input  logic        mis_pred_in,
  input  logic [1:0]  lbd_state_in,
  input  logic        rslv_vld_in,
  input  logic [15:0] rslv_pc_in,
  input  logic        rslv_tkn_in,
  input  logic        rslv_bck_in,
  output logic [63:0] inst_out,
  output logic [63:0] pc_out,
  output logic [3:0]  inst_valid_out,
  output logic [3:0]  bck_lp_bus_out
);

  localparam int         TAG_W    = 16 - IDX_W;
  localparam logic [1:0] THRESH_C = 2'(THRESH);

  logic [ENTRIES-1:0] r_vld;
  logic [TAG_W-1:0]   r_tag [ENTRIES];
  logic [1:0]         r_cnt [ENTRIES];

  logic [63:0] r_inst;
  logic [63:0] r_pc;
  logic [3:0]  r_inst_vld;
  logic [3:0]  r_bus;

  logic [3:0]  w_cand;
  logic [3:0]  w_bus;
  logic [3:0]  w_mask;
  logic [IDX_W-1:0] w_r_idx;
  logic [TAG_W-1:0] w_r_tag;
  logic        w_r_hit;
  logic        w_upd;

  // Candidate decode; bit 3 of every 4-bit vector is slot0 (the oldest).
  always_comb begin
    logic [15:0]      w_inst_s;
    logic [15:0]      w_pc_s;
    logic [IDX_W-1:0] w_idx_s;
    logic             w_br_s;
    logic             w_hit_s;
    w_cand = 4'b0000;
    for (int s = 0; s < 4; s++) begin
      w_inst_s = inst_in[63-16*s -: 16];
      w_pc_s   = pc_in[63-16*s -: 16];
      w_idx_s  = w_pc_s[IDX_W-1:0];
      w_br_s   = (w_inst_s[15:12] == BR_OPC) && w_inst_s[7];
      w_hit_s  = r_vld[w_idx_s] && (r_tag[w_idx_s] == w_pc_s[15:IDX_W])
                 && (r_cnt[w_idx_s] >= THRESH_C);
      w_cand[3-s] = inst_valid_in[3-s] && w_br_s && w_hit_s
                    && (lbd_state_in == 2'b00);
    end
  end

  // Oldest candidate wins; everything younger than it is off-path.
  always_comb begin
    w_bus  = 4'b0000;
    w_mask = 4'b1111;
    if (w_cand[3]) begin
      w_bus  = 4'b1000;
      w_mask = 4'b1000;
    end else if (w_cand[2]) begin
      w_bus  = 4'b0100;
      w_mask = 4'b1100;
    end else if (w_cand[1]) begin
      w_bus  = 4'b0010;
      w_mask = 4'b1110;
    end else if (w_cand[0]) begin
      w_bus  = 4'b0001;
      w_mask = 4'b1111;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_inst     <= '0;
      r_pc       <= '0;
      r_inst_vld <= '0;
      r_bus      <= '0;
    end else if (mis_pred_in) begin
      r_inst_vld <= '0;
      r_bus      <= '0;
      if (!stall_in) begin
        r_inst <= inst_in;
        r_pc   <= pc_in;
      end
    end else if (!stall_in) begin
      r_inst     <= inst_in;
      r_pc       <= pc_in;
      r_inst_vld <= inst_valid_in & w_mask;
      r_bus      <= w_bus;
    end
  end

  assign w_r_idx = rslv_pc_in[IDX_W-1:0];
  assign w_r_tag = rslv_pc_in[15:IDX_W];
  assign w_r_hit = r_vld[w_r_idx] && (r_tag[w_r_idx] == w_r_tag);
  assign w_upd   = rslv_vld_in && rslv_bck_in;

  // Lookup above reads these registers before this edge writes them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vld <= '0;
      for (int e = 0; e < ENTRIES; e++) begin
        r_tag[e] <= '0;
        r_cnt[e] <= '0;
      end
    end else if (w_upd) begin
      if (rslv_tkn_in) begin
        if (w_r_hit) begin
          if (r_cnt[w_r_idx] != 2'd3) r_cnt[w_r_idx] <= r_cnt[w_r_idx] + 2'd1;
        end else begin
          r_vld[w_r_idx] <= 1'b1;
          r_tag[w_r_idx] <= w_r_tag;
          r_cnt[w_r_idx] <= 2'd1;
        end
      end else if (w_r_hit) begin
        r_cnt[w_r_idx] <= 2'd0;
      end
    end
  end

  assign inst_out       = r_inst;
  assign pc_out         = r_pc;
  assign inst_valid_out = r_inst_vld;
  assign bck_lp_bus_out = r_bus;

endmodule

// File: tb/tb_bck_lp_dtct.sv
// Directed bench for bck_lp_dtct: vector table for training, priority and
// aliasing, plus hand sequences for stall, flush and asynchronous reset.
module tb_bck_lp_dtct;

  logic        clk;
  logic        rst;
  logic [63:0] inst_in;
  logic [63:0] pc_in;
  logic [3:0]  inst_valid_in;
  logic        stall_in;
  logic        mis_pred_in;
  logic [1:0]  lbd_state_in;
  logic        rslv_vld_in;
  logic [15:0] rslv_pc_in;
  logic        rslv_tkn_in;
  logic        rslv_bck_in;
  logic [63:0] inst_out;
  logic [63:0] pc_out;
  logic [3:0]  inst_valid_out;
  logic [3:0]  bck_lp_bus_out;

  bck_lp_dtct dut (
    .clk            (clk),
    .rst            (rst),
    .inst_in        (inst_in),
    .pc_in          (pc_in),
    .inst_valid_in  (inst_valid_in),
    .stall_in       (stall_in),
    .mis_pred_in    (mis_pred_in),
    .lbd_state_in   (lbd_state_in),
    .rslv_vld_in    (rslv_vld_in),
    .rslv_pc_in     (rslv_pc_in),
    .rslv_tkn_in    (rslv_tkn_in),
    .rslv_bck_in    (rslv_bck_in),
    .inst_out       (inst_out),
    .pc_out         (pc_out),
    .inst_valid_out (inst_valid_out),
    .bck_lp_bus_out (bck_lp_bus_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [63:0] A_INST = {16'h0000, 16'hC0FC, 16'h0000, 16'h0000};
  localparam logic [63:0] A_PC   = {16'h0012, 16'h0013, 16'h0014, 16'h0015};
  localparam logic [63:0] B_INST = {16'hC0F0, 16'h0000, 16'hC0F8, 16'h0000};
  localparam logic [63:0] B_PC   = {16'h0020, 16'h0021, 16'h0022, 16'h0023};
  localparam logic [63:0] C_INST = {16'h0000, 16'h0000, 16'h0000, 16'hC0FC};
  localparam logic [63:0] C_PC   = {16'h0018, 16'h0019, 16'h001A, 16'h001B};
  localparam logic [63:0] D_INST = {16'hC070, 16'h0000, 16'hB0F8, 16'h0000};

  typedef struct {
    logic        rv;
    logic [15:0] rpc;
    logic        rt;
    logic        rb;
    logic [63:0] inst;
    logic [63:0] pc;
    logic [3:0]  vld;
    logic [1:0]  lbd;
    logic [3:0]  e_vld;
    logic [3:0]  e_bus;
  } vec_t;

  vec_t vt [32];
  int   nv;
  int   n_chk;
  int   n_fail;

  task automatic add(input logic rv, input logic [15:0] rpc, input logic rt,
                     input logic rb, input logic [63:0] inst, input logic [63:0] pc,
                     input logic [3:0] vld, input logic [1:0] lbd,
                     input logic [3:0] e_vld, input logic [3:0] e_bus);
    vt[nv] = '{rv, rpc, rt, rb, inst, pc, vld, lbd, e_vld, e_bus};
    nv++;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [63:0] inst, input logic [63:0] pc,
                       input logic [3:0] vld, input logic stall, input logic mis,
                       input logic [1:0] lbd, input logic rv, input logic [15:0] rpc,
                       input logic rt, input logic rb);
    inst_in       = inst;
    pc_in         = pc;
    inst_valid_in = vld;
    stall_in      = stall;
    mis_pred_in   = mis;
    lbd_state_in  = lbd;
    rslv_vld_in   = rv;
    rslv_pc_in    = rpc;
    rslv_tkn_in   = rt;
    rslv_bck_in   = rb;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_inst"}, inst_out, 64'h0);
    chk({name, "_pc"},   pc_out,   64'h0);
    chk({name, "_vld"},  {60'h0, inst_valid_out}, 64'h0);
    chk({name, "_bus"},  {60'h0, bck_lp_bus_out}, 64'h0);
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    nv     = 0;

    //   rv  rpc       rt  rb  inst    pc    vld     lbd    e_vld   e_bus
    add(0, 16'h0000, 0, 0, A_INST, A_PC, 4'b1111, 2'b00, 4'b1111, 4'b0000); // untrained
    add(1, 16'h0013, 1, 1, 64'h0,  64'h0, 4'b0000, 2'b00, 4'b0000, 4'b0000); // cnt 1
    add(0, 16'h0000, 0, 0, A_INST, A_PC, 4'b1111, 2'b00, 4'b1111, 4'b0000);
    add(1, 16'h0013, 1, 1, A_INST, A_PC, 4'b1111, 2'b00, 4'b1111, 4'b0000); // sees old cnt 1
    add(0, 16'h0000, 0, 0, A_INST, A_PC, 4'b1111, 2'b00, 4'b1100, 4'b0100);
    add(0, 16'h0000, 0, 0, A_INST, A_PC, 4'b1111, 2'b01, 4'b1111, 4'b0000); // LAT busy
    add(0, 16'h0000, 0, 0, A_INST, A_PC, 4'b1011, 2'b00, 4'b1011, 4'b0000); // slot1 invalid
    add(1, 16'h0020, 1, 1, 64'h0,  64'h0, 4'b0000, 2'b00, 4'b0000, 4'b0000);
    add(1, 16'h0020, 1, 1, 64'h0,  64'h0, 4'b0000, 2'b00, 4'b0000, 4'b0000);
    add(1, 16'h0022, 1, 1, 64'h0,  64'h0, 4'b0000, 2'b00, 4'b0000, 4'b0000);
    add(1, 16'h0022, 1, 1, 64'h0,  64'h0, 4'b0000, 2'b00, 4'b0000, 4'b0000);
    add(0, 16'h0000, 0, 0, B_INST, B_PC, 4'b1111, 2'b00, 4'b1000, 4'b1000); // slot0 wins
    add(0, 16'h0000, 0, 0, B_INST, B_PC, 4'b0111, 2'b00, 4'b0110, 4'b0010);
    add(0, 16'h0000, 0, 0, D_INST, B_PC, 4'b1111, 2'b00, 4'b1111, 4'b0000); // fwd / wrong opc
    add(1, 16'h0013, 1, 1, 64'h0,  64'h0, 4'b0000, 2'b00, 4'b0000, 4'b0000); // cnt 3
    add(1, 16'h0013, 1, 1, A_INST, A_PC, 4'b1111, 2'b00, 4'b1100, 4'b0100); // saturates
    add(0, 16'h0000, 0, 0, A_INST, A_PC, 4'b1111, 2'b00, 4'b1100, 4'b0100);
    add(1, 16'h0013, 0, 1, 64'h0,  64'h0, 4'b0000, 2'b00, 4'b0000, 4'b0000); // loop exit
    add(0, 16'h0000, 0, 0, A_INST, A_PC, 4'b1111, 2'b00, 4'b1111, 4'b0000);
    add(1, 16'h0013, 1, 0, 64'h0,  64'h0, 4'b0000, 2'b00, 4'b0000, 4'b0000); // forward: ignored
    add(0, 16'h0013, 1, 1, 64'h0,  64'h0, 4'b0000, 2'b00, 4'b0000, 4'b0000); // not valid
    add(1, 16'h0013, 1, 0, A_INST, A_PC, 4'b1111, 2'b00, 4'b1111, 4'b0000);
    add(1, 16'h0013, 1, 1, 64'h0,  64'h0, 4'b0000, 2'b00, 4'b0000, 4'b0000); // cnt 1
    add(1, 16'h0013, 1, 1, 64'h0,  64'h0, 4'b0000, 2'b00, 4'b0000, 4'b0000); // cnt 2
    add(0, 16'h0000, 0, 0, A_INST, A_PC, 4'b1111, 2'b00, 4'b1100, 4'b0100);
    add(1, 16'h001B, 1, 1, 64'h0,  64'h0, 4'b0000, 2'b00, 4'b0000, 4'b0000); // evicts 0x13
    add(1, 16'h001B, 1, 1, A_INST, A_PC, 4'b1111, 2'b00, 4'b1111, 4'b0000);
    add(1, 16'h0013, 0, 1, C_INST, C_PC, 4'b1111, 2'b00, 4'b1111, 4'b0001); // NT miss
    add(0, 16'h0000, 0, 0, C_INST, C_PC, 4'b1111, 2'b00, 4'b1111, 4'b0001);
    add(0, 16'h0000, 0, 0, A_INST, A_PC, 4'b0000, 2'b00, 4'b0000, 4'b0000);

    rst = 1'b0;
    drive(A_INST, A_PC, 4'b1111, 0, 0, 2'b00, 0, 16'h0, 0, 0);
    #2;
    chk_all_zero("reset_init");
    #20;
    rst = 1'b1;
    #2;

    for (int i = 0; i < nv; i++) begin
      drive(vt[i].inst, vt[i].pc, vt[i].vld, 0, 0, vt[i].lbd,
            vt[i].rv, vt[i].rpc, vt[i].rt, vt[i].rb);
      tick();
      chk($sformatf("vec%0d_bus", i), {60'h0, bck_lp_bus_out}, {60'h0, vt[i].e_bus});
      chk($sformatf("vec%0d_vld", i), {60'h0, inst_valid_out}, {60'h0, vt[i].e_vld});
      chk($sformatf("vec%0d_inst", i), inst_out, vt[i].inst);
      chk($sformatf("vec%0d_pc", i), pc_out, vt[i].pc);
    end

    // Stall holds outputs; the table still trains (0x22 counter cleared).
    drive(B_INST, B_PC, 4'b1111, 0, 0, 2'b00, 0, 16'h0, 0, 0);
    tick();
    chk("pre_stall_bus", {60'h0, bck_lp_bus_out}, {60'h0, 4'b1000});
    for (int c = 0; c < 3; c++) begin
      drive(A_INST, A_PC, 4'b1111, 1, 0, 2'b00, (c == 0), 16'h0022, 0, 1);
      tick();
      chk($sformatf("stall%0d_bus", c), {60'h0, bck_lp_bus_out}, {60'h0, 4'b1000});
      chk($sformatf("stall%0d_vld", c), {60'h0, inst_valid_out}, {60'h0, 4'b1000});
      chk($sformatf("stall%0d_inst", c), inst_out, B_INST);
      chk($sformatf("stall%0d_pc", c), pc_out, B_PC);
    end

    drive(A_INST, A_PC, 4'b1111, 1, 1, 2'b00, 0, 16'h0, 0, 0);
    tick();
    chk("flush_stall_vld", {60'h0, inst_valid_out}, 64'h0);
    chk("flush_stall_bus", {60'h0, bck_lp_bus_out}, 64'h0);

    drive(B_INST, B_PC, 4'b0111, 0, 0, 2'b00, 0, 16'h0, 0, 0);
    tick();
    chk("stall_train_bus", {60'h0, bck_lp_bus_out}, 64'h0);
    chk("stall_train_vld", {60'h0, inst_valid_out}, {60'h0, 4'b0111});

    drive(B_INST, B_PC, 4'b1111, 0, 1, 2'b00, 0, 16'h0, 0, 0);
    tick();
    chk("flush_vld", {60'h0, inst_valid_out}, 64'h0);
    chk("flush_bus", {60'h0, bck_lp_bus_out}, 64'h0);

    // Asynchronous reset mid-cycle, then the table must be empty.
    drive(B_INST, B_PC, 4'b1111, 0, 0, 2'b00, 0, 16'h0, 0, 0);
    tick();
    chk("pre_rst_bus", {60'h0, bck_lp_bus_out}, {60'h0, 4'b1000});
    #2;
    rst = 1'b0;
    #1;
    chk_all_zero("reset_mid");
    #2;
    rst = 1'b1;
    tick();
    chk("post_rst_b_bus", {60'h0, bck_lp_bus_out}, 64'h0);
    chk("post_rst_b_vld", {60'h0, inst_valid_out}, {60'h0, 4'b1111});
    drive(A_INST, A_PC, 4'b1111, 0, 0, 2'b00, 0, 16'h0, 0, 0);
    tick();
    chk("post_rst_a_bus", {60'h0, bck_lp_bus_out}, 64'h0);
    chk("post_rst_a_vld", {60'h0, inst_valid_out}, {60'h0, 4'b1111});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
